// File: rtl/rd_guard_isolator.sv
// rd_guard_isolator
// -----------------
// Enforcement stage behind the AXI read guard. The block sits between the read
// master and the monitored slave, and every read the slave accepts is recorded
// in a small circular table.
//
// When the guard raises reset_req_i, the block does the following in order:
//   1. It fences the AR channel.
//   2. It lets any stalled R beat finish.
//   3. It answers every still-outstanding read with SLVERR beats.
//   4. It holds the slave in reset for RstHoldCycles cycles.
//   5. It pulses reset_clear_o once back to the guard.
//
// Optional feature macro: RD_ISO_ERR_RESP_EN
//   defined   : outstanding reads are answered with SLVERR beats (ERR state).
//   undefined : ISOLATE goes straight to RESET. The table is flushed without
//               any master responses. Use this only when the master is reset
//               as well.
//
// Parameters:
//   IdWidth, DataWidth, MaxRdTxns (power of two, >= 2), RstHoldCycles (>= 1)
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   reset_req_i                abort request from the read guard (level)
//   reset_clear_o              one-cycle clear pulse back to the guard
//   slv_rst_o                  slave reset, active-high
//   isolated_o                 high whenever the FSM is not IDLE
//   mst_ar_* / slv_ar_*        AR handshake (payload is wired around this block)
//   slv_r_* -> mst_r_*         R channel, passthrough or locally generated errors
module rd_guard_isolator #(
    parameter int IdWidth       = 4,
    parameter int DataWidth     = 64,
    parameter int MaxRdTxns     = 8,
    parameter int RstHoldCycles = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 reset_req_i,
    output logic                 reset_clear_o,
    output logic                 slv_rst_o,
    output logic                 isolated_o,
    input  logic                 mst_ar_valid_i,
    output logic                 mst_ar_ready_o,
    input  logic [IdWidth-1:0]   mst_ar_id_i,
    input  logic [7:0]           mst_ar_len_i,
    output logic                 slv_ar_valid_o,
    input  logic                 slv_ar_ready_i,
    input  logic                 slv_r_valid_i,
    output logic                 slv_r_ready_o,
    input  logic [IdWidth-1:0]   slv_r_id_i,
    input  logic [DataWidth-1:0] slv_r_data_i,
    input  logic [1:0]           slv_r_resp_i,
    input  logic                 slv_r_last_i,
    output logic                 mst_r_valid_o,
    input  logic                 mst_r_ready_i,
    output logic [IdWidth-1:0]   mst_r_id_o,
    output logic [DataWidth-1:0] mst_r_data_o,
    output logic [1:0]           mst_r_resp_o,
    output logic                 mst_r_last_o
);

    localparam int PtrW  = $clog2(MaxRdTxns);
    localparam int CntW  = PtrW + 1;
    localparam int HoldW = $clog2(RstHoldCycles + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISOLATE,
        ST_ERR,
        ST_RESET,
        ST_CLEAR
    } state_e;

    state_e state_q, state_d;

    logic [MaxRdTxns-1:0] tbl_valid_q;
    logic [IdWidth-1:0]   tbl_id_q    [MaxRdTxns];
    logic [7:0]           tbl_len_q   [MaxRdTxns];
    logic [7:0]           tbl_beats_q [MaxRdTxns];
    logic [PtrW-1:0]      head_q, tail_q;
    logic [CntW-1:0]      count_q;
    logic [HoldW-1:0]     hold_q;
    logic                 clear_done_q;

    logic                 full, alloc, reclaim, flush, passthru;
    logic                 match_found;
    logic [PtrW-1:0]      match_idx, match_scan;
    logic                 rel_fire, rel_last;
    logic [PtrW-1:0]      rel_idx;

    assign full    = (count_q == CntW'(MaxRdTxns));
    assign alloc   = slv_ar_valid_o & slv_ar_ready_i;
    assign reclaim = (count_q != '0) && !tbl_valid_q[head_q];
    assign flush   = (state_q == ST_RESET) || (state_q == ST_CLEAR);

    // A returning beat belongs to the oldest live read with the same id.
    // The scan therefore starts at head and wraps around the table.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        match_scan  = '0;
        for (int i = 0; i < MaxRdTxns; i++) begin
            match_scan = head_q + PtrW'(i);
            if (!match_found && tbl_valid_q[match_scan] &&
                (tbl_id_q[match_scan] == slv_r_id_i)) begin
                match_found = 1'b1;
                match_idx   = match_scan;
            end
        end
    end

`ifdef RD_ISO_ERR_RESP_EN
    logic            err_found;
    logic [PtrW-1:0] err_idx, err_scan;

    // Error responses go out in allocation order. The target is the first
    // live entry from head, so gaps left by out-of-order completion cost no
    // bubble cycles.
    always_comb begin
        err_found = 1'b0;
        err_idx   = '0;
        err_scan  = '0;
        for (int i = 0; i < MaxRdTxns; i++) begin
            err_scan = head_q + PtrW'(i);
            if (!err_found && tbl_valid_q[err_scan]) begin
                err_found = 1'b1;
                err_idx   = err_scan;
            end
        end
    end
`endif

    always_comb begin
        state_d        = state_q;
        passthru       = 1'b0;
        slv_ar_valid_o = 1'b0;
        mst_ar_ready_o = 1'b0;
        slv_r_ready_o  = 1'b0;
        mst_r_valid_o  = 1'b0;
        mst_r_id_o     = '0;
        mst_r_data_o   = '0;
        mst_r_resp_o   = 2'b00;
        mst_r_last_o   = 1'b0;
        slv_rst_o      = 1'b0;
        reset_clear_o  = 1'b0;
        isolated_o     = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                slv_ar_valid_o = mst_ar_valid_i & ~full;
                mst_ar_ready_o = slv_ar_ready_i & ~full;
                passthru       = 1'b1;
                if (reset_req_i) begin
                    state_d = ST_ISOLATE;
                end
            end
            ST_ISOLATE: begin
                // Stay here while a beat is stalled on the master side. This
                // lets the master see an unbroken handshake before the R path
                // is cut.
                passthru = 1'b1;
                if (!(slv_r_valid_i && !mst_r_ready_i)) begin
`ifdef RD_ISO_ERR_RESP_EN
                    state_d = ST_ERR;
`else
                    state_d = ST_RESET;
`endif
                end
            end
            ST_ERR: begin
`ifdef RD_ISO_ERR_RESP_EN
                slv_r_ready_o = 1'b1;
                if (err_found) begin
                    mst_r_valid_o = 1'b1;
                    mst_r_id_o    = tbl_id_q[err_idx];
                    mst_r_resp_o  = 2'b10;
                    mst_r_last_o  = (tbl_beats_q[err_idx] == tbl_len_q[err_idx]);
                end else begin
                    state_d = ST_RESET;
                end
`else
                state_d = ST_RESET;
`endif
            end
            ST_RESET: begin
                slv_rst_o = 1'b1;
                if (hold_q == HoldW'(RstHoldCycles - 1)) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                reset_clear_o = ~clear_done_q;
                if (!reset_req_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (passthru) begin
            mst_r_valid_o = slv_r_valid_i;
            mst_r_id_o    = slv_r_id_i;
            mst_r_data_o  = slv_r_data_i;
            mst_r_resp_o  = slv_r_resp_i;
            mst_r_last_o  = slv_r_last_i;
            slv_r_ready_o = mst_r_ready_i;
        end
    end

    // A beat that matches no entry is forwarded but leaves the table untouched.
    always_comb begin
        rel_fire = 1'b0;
        rel_idx  = match_idx;
        rel_last = slv_r_last_i;
        if (passthru) begin
            rel_fire = slv_r_valid_i & mst_r_ready_i & match_found;
        end
`ifdef RD_ISO_ERR_RESP_EN
        else if (state_q == ST_ERR) begin
            rel_fire = mst_r_valid_o & mst_r_ready_i;
            rel_idx  = err_idx;
            rel_last = mst_r_last_o;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= (state_q == ST_RESET) ? hold_q + HoldW'(1) : '0;
            clear_done_q <= (state_q == ST_CLEAR);
        end
    end

    // Only the valid bits and pointers need a reset; payload fields are read
    // only behind a set valid bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tbl_valid_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else if (flush) begin
            tbl_valid_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            if (alloc) begin
                tbl_valid_q[tail_q] <= 1'b1;
                tail_q              <= tail_q + PtrW'(1);
            end
            if (rel_fire && rel_last) begin
                tbl_valid_q[rel_idx] <= 1'b0;
            end
            if (reclaim) begin
                head_q <= head_q + PtrW'(1);
            end
            case ({alloc, reclaim})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc) begin
            tbl_id_q[tail_q]    <= mst_ar_id_i;
            tbl_len_q[tail_q]   <= mst_ar_len_i;
            tbl_beats_q[tail_q] <= 8'd0;
        end
        if (rel_fire) begin
            tbl_beats_q[rel_idx] <= tbl_beats_q[rel_idx] + 8'd1;
        end
    end

endmodule

// File: tb/tb_rd_guard_isolator.sv
// tb_rd_guard_isolator
// --------------------
// Self-checking bench for rd_guard_isolator.
//
// The bench acts as both the read master and the monitored slave. A reference
// model keeps the outstanding reads as a queue in allocation order.
//
// Delivered slave beats and the SLVERR beats the model predicts after an abort
// are pushed into a scoreboard queue. An independent monitor pops and compares
// that queue on every master R handshake.
module tb_rd_guard_isolator;

    localparam int IdWidth       = 4;
    localparam int DataWidth     = 64;
    localparam int MaxRdTxns     = 8;
    localparam int RstHoldCycles = 16;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 reset_req_i;
    logic                 reset_clear_o, slv_rst_o, isolated_o;
    logic                 mst_ar_valid_i, mst_ar_ready_o;
    logic [IdWidth-1:0]   mst_ar_id_i;
    logic [7:0]           mst_ar_len_i;
    logic                 slv_ar_valid_o, slv_ar_ready_i;
    logic                 slv_r_valid_i, slv_r_ready_o;
    logic [IdWidth-1:0]   slv_r_id_i;
    logic [DataWidth-1:0] slv_r_data_i;
    logic [1:0]           slv_r_resp_i;
    logic                 slv_r_last_i;
    logic                 mst_r_valid_o, mst_r_ready_i;
    logic [IdWidth-1:0]   mst_r_id_o;
    logic [DataWidth-1:0] mst_r_data_o;
    logic [1:0]           mst_r_resp_o;
    logic                 mst_r_last_o;

    always #5 clk_i = ~clk_i;

    rd_guard_isolator #(
        .IdWidth      (IdWidth),
        .DataWidth    (DataWidth),
        .MaxRdTxns    (MaxRdTxns),
        .RstHoldCycles(RstHoldCycles)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .reset_req_i   (reset_req_i),
        .reset_clear_o (reset_clear_o),
        .slv_rst_o     (slv_rst_o),
        .isolated_o    (isolated_o),
        .mst_ar_valid_i(mst_ar_valid_i),
        .mst_ar_ready_o(mst_ar_ready_o),
        .mst_ar_id_i   (mst_ar_id_i),
        .mst_ar_len_i  (mst_ar_len_i),
        .slv_ar_valid_o(slv_ar_valid_o),
        .slv_ar_ready_i(slv_ar_ready_i),
        .slv_r_valid_i (slv_r_valid_i),
        .slv_r_ready_o (slv_r_ready_o),
        .slv_r_id_i    (slv_r_id_i),
        .slv_r_data_i  (slv_r_data_i),
        .slv_r_resp_i  (slv_r_resp_i),
        .slv_r_last_i  (slv_r_last_i),
        .mst_r_valid_o (mst_r_valid_o),
        .mst_r_ready_i (mst_r_ready_i),
        .mst_r_id_o    (mst_r_id_o),
        .mst_r_data_o  (mst_r_data_o),
        .mst_r_resp_o  (mst_r_resp_o),
        .mst_r_last_o  (mst_r_last_o)
    );

    typedef struct {
        logic [IdWidth-1:0] id;
        int                 len;
        int                 sent;
    } txn_t;

    typedef logic [IdWidth+DataWidth+2:0] beat_t;

    txn_t  txns[$];
    beat_t exp_q[$];
    int    checks       = 0;
    int    errors       = 0;
    int    rst_cycles   = 0;
    int    clear_pulses = 0;

    function automatic beat_t pack_beat(input logic [IdWidth-1:0] id, input logic [DataWidth-1:0] d,
                                        input logic [1:0] r, input logic l);
        return {id, d, r, l};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard monitor: every master R handshake consumes one expected beat.
    // A beat stalled by the master must reappear unchanged on the next cycle.
    logic  prev_stall = 1'b0;
    beat_t prev_beat;
    always @(negedge clk_i) begin
        beat_t cur;
        cur = pack_beat(mst_r_id_o, mst_r_data_o, mst_r_resp_o, mst_r_last_o);
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("r_hold_stable", 128'({mst_r_valid_o, cur}), 128'({1'b1, prev_beat}));
            end
            if (mst_r_valid_o && mst_r_ready_i) begin
                if (exp_q.size() == 0) begin
                    checkOutput("r_unexpected_beat", 128'(mst_r_valid_o), 128'(0));
                end else begin
                    checkOutput("r_beat", 128'(cur), 128'(exp_q.pop_front()));
                end
            end
            prev_stall = mst_r_valid_o && !mst_r_ready_i;
            prev_beat  = cur;
        end
    end

    always @(negedge clk_i) begin
        if (slv_rst_o) rst_cycles++;
        if (reset_clear_o) clear_pulses++;
    end

    task automatic issueAr(input logic [IdWidth-1:0] id, input int len);
        int  n;
        bit  hs;
        mst_ar_valid_i = 1'b1;
        mst_ar_id_i    = id;
        mst_ar_len_i   = 8'(len);
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 200) begin
            slv_ar_ready_i = ($urandom_range(0, 2) != 0);
            @(negedge clk_i);
            hs = mst_ar_ready_o && slv_ar_valid_o;
            stepCycle();
            n++;
        end
        if (!hs) checkOutput("ar_handshake_timeout", 128'(mst_ar_ready_o), 128'(1));
        else     txns.push_back('{id: id, len: len, sent: 0});
        mst_ar_valid_i = 1'b0;
        slv_ar_ready_i = 1'b0;
    endtask

    // Slave returns one beat for the oldest read sharing an id with txns[k].
    // With stall_only the beat is left pending and the master is not ready.
    task automatic driveBeat(input int k, input bit stall_only);
        int j;
        int n;
        bit hs;
        logic [DataWidth-1:0] d;
        logic [1:0] r;
        logic l;
        j = k;
        for (int i = 0; i < txns.size(); i++) begin
            if (txns[i].id == txns[k].id) begin
                j = i;
                break;
            end
        end
        d = {$urandom, $urandom};
        r = 2'($urandom_range(0, 3));
        l = (txns[j].sent == txns[j].len);
        slv_r_valid_i = 1'b1;
        slv_r_id_i    = txns[j].id;
        slv_r_data_i  = d;
        slv_r_resp_i  = r;
        slv_r_last_i  = l;
        exp_q.push_back(pack_beat(txns[j].id, d, r, l));
        txns[j].sent++;
        if (l) txns.delete(j);
        if (stall_only) begin
            mst_r_ready_i = 1'b0;
            return;
        end
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 200) begin
            mst_r_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk_i);
            hs = slv_r_valid_i && slv_r_ready_o;
            stepCycle();
            n++;
        end
        if (!hs) checkOutput("r_beat_timeout", 128'(slv_r_ready_o), 128'(1));
        slv_r_valid_i = 1'b0;
        slv_r_data_i  = '0;
        slv_r_last_i  = 1'b0;
    endtask

    task automatic pushErrBeats();
`ifdef RD_ISO_ERR_RESP_EN
        foreach (txns[i]) begin
            for (int b = txns[i].sent; b <= txns[i].len; b++) begin
                exp_q.push_back(pack_beat(txns[i].id, '0, 2'b10, b == txns[i].len));
            end
        end
`endif
        txns.delete();
    endtask

    task automatic runAbort(input bit stalled, input bit with_ar);
        int base_rst;
        int base_clr;
        int n;
        bit hs;
        logic [IdWidth-1:0] ar_id;
        int ar_len;
        base_rst = rst_cycles;
        base_clr = clear_pulses;
        ar_id    = IdWidth'($urandom_range(0, 7));
        ar_len   = $urandom_range(0, 3);
        if (stalled && txns.size() > 0) driveBeat($urandom_range(0, txns.size() - 1), 1'b1);
        else stalled = 1'b0;
        reset_req_i = 1'b1;
        if (with_ar) begin
            mst_ar_valid_i = 1'b1;
            slv_ar_ready_i = 1'b1;
            mst_ar_id_i    = ar_id;
            mst_ar_len_i   = 8'(ar_len);
        end
        @(negedge clk_i);
        checkOutput("isolate_not_yet", 128'(isolated_o), 128'(0));
        if (with_ar) begin
            checkOutput("ar_same_cycle_as_req", 128'(mst_ar_ready_o), 128'(1));
            if (mst_ar_ready_o) txns.push_back('{id: ar_id, len: ar_len, sent: 0});
        end
        pushErrBeats();
        stepCycle();
        mst_ar_valid_i = 1'b0;
        slv_ar_ready_i = 1'b0;
        n = 0;
        while (clear_pulses == base_clr && n < 3000) begin
            if (stalled && n < 4) mst_r_ready_i = 1'b0;
            else mst_r_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk_i);
            if (n == 0) checkOutput("isolate_entered", 128'(isolated_o), 128'(1));
            if (stalled && n == 2) begin
                checkOutput("stall_keeps_isolate", 128'({slv_rst_o, mst_r_valid_o}), 128'(2'b01));
            end
            hs = slv_r_valid_i && slv_r_ready_o;
            stepCycle();
            if (hs) begin
                slv_r_valid_i = 1'b0;
                slv_r_data_i  = '0;
                slv_r_last_i  = 1'b0;
            end
            n++;
        end
        mst_r_ready_i = 1'b0;
        repeat (3) stepCycle();
        @(negedge clk_i);
        checkOutput("clear_holds_isolation", 128'(isolated_o), 128'(1));
        stepCycle();
        reset_req_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (isolated_o && n < 20);
        checkOutput("back_to_idle", 128'(isolated_o), 128'(0));
        checkOutput("slv_rst_cycles", 128'(rst_cycles - base_rst), 128'(RstHoldCycles));
        checkOutput("clear_pulse_count", 128'(clear_pulses - base_clr), 128'(1));
        checkOutput("err_beats_drained", 128'(exp_q.size()), 128'(0));
        stepCycle();
    endtask

    task automatic completeAll();
        while (txns.size() > 0) driveBeat($urandom_range(0, txns.size() - 1), 1'b0);
        repeat (2) stepCycle();
        checkOutput("passthrough_drained", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic applyStimulus(input int iterations);
        int k;
        int d;
        for (int it = 0; it < iterations; it++) begin
            k = $urandom_range(1, 6);
            for (int a = 0; a < k; a++) begin
                issueAr(IdWidth'($urandom_range(0, 3)), $urandom_range(0, 4));
            end
            d = $urandom_range(0, 6);
            for (int b = 0; b < d && txns.size() > 0; b++) begin
                driveBeat($urandom_range(0, txns.size() - 1), 1'b0);
            end
            if (it % 3 == 0) completeAll();
            else runAbort(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        int n;
        rst_i          = 1'b1;
        reset_req_i    = 1'b0;
        mst_ar_valid_i = 1'b0;
        mst_ar_id_i    = '0;
        mst_ar_len_i   = '0;
        slv_ar_ready_i = 1'b0;
        slv_r_valid_i  = 1'b0;
        slv_r_id_i     = '0;
        slv_r_data_i   = '0;
        slv_r_resp_i   = 2'b00;
        slv_r_last_i   = 1'b0;
        mst_r_ready_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_ctrl_outputs",
                    128'({isolated_o, slv_rst_o, reset_clear_o, mst_r_valid_o, slv_ar_valid_o, mst_ar_ready_o}),
                    128'(0));
        checkOutput("reset_r_payload",
                    128'(pack_beat(mst_r_id_o, mst_r_data_o, mst_r_resp_o, mst_r_last_o)), 128'(0));
        stepCycle();
        rst_i = 1'b0;
        repeat (3) stepCycle();
        checkOutput("idle_no_clear_pulse", 128'(clear_pulses), 128'(0));

        $display("[TB] passthrough id=3 len=3");
        issueAr(4'd3, 3);
        repeat (4) driveBeat(0, 1'b0);
        completeAll();

        $display("[TB] abort mid-burst id=1 len=7");
        issueAr(4'd1, 7);
        repeat (3) driveBeat(0, 1'b0);
        runAbort(1'b0, 1'b0);

        $display("[TB] stalled beat at abort");
        issueAr(4'd5, 2);
        driveBeat(0, 1'b0);
        runAbort(1'b1, 1'b0);

        $display("[TB] same-id ordering");
        issueAr(4'd2, 0);
        issueAr(4'd2, 1);
        runAbort(1'b0, 1'b0);

        $display("[TB] AR in the same cycle as the request");
        issueAr(4'd4, 1);
        runAbort(1'b0, 1'b1);

        $display("[TB] async reset during slave reset");
        issueAr(4'd6, 2);
        issueAr(4'd7, 0);
        pushErrBeats();
        reset_req_i = 1'b1;
        n = 0;
        do begin
            mst_r_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk_i);
            n++;
        end while (!slv_rst_o && n < 2000);
        checkOutput("reached_reset_state", 128'(slv_rst_o), 128'(1));
        checkOutput("err_drained_before_reset", 128'(exp_q.size()), 128'(0));
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("async_rst_outputs", 128'({slv_rst_o, isolated_o}), 128'(0));
        exp_q.delete();
        stepCycle();
        rst_i       = 1'b0;
        reset_req_i = 1'b0;
        mst_r_ready_i = 1'b0;
        stepCycle();

        $display("[TB] table full");
        for (int a = 0; a < MaxRdTxns; a++) issueAr(IdWidth'($urandom_range(0, 3)), $urandom_range(0, 3));
        mst_ar_valid_i = 1'b1;
        slv_ar_ready_i = 1'b1;
        mst_ar_id_i    = 4'd9;
        mst_ar_len_i   = 8'd1;
        repeat (3) begin
            @(negedge clk_i);
            checkOutput("full_blocks_ar", 128'({mst_ar_ready_o, slv_ar_valid_o}), 128'(0));
            stepCycle();
        end
        mst_ar_valid_i = 1'b0;
        slv_ar_ready_i = 1'b0;
        n = txns[0].len + 1 - txns[0].sent;
        repeat (n) driveBeat(0, 1'b0);
        issueAr(4'd9, 1);
        runAbort(1'b0, 1'b0);

        $display("[TB] randomized scenarios");
        applyStimulus(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
